// File: rtl/neuron_mac_if.sv
// Beat stream into a neuron accumulator and finished-sum handoff to the activation stage.
interface neuron_mac_if #(
  parameter int dataWidth   = 16,
  parameter int weightWidth = 16,
  parameter int sumWidth    = 32
);
  logic                   in_valid;
  logic                   in_ready;
  logic [dataWidth-1:0]   in_data;
  logic [weightWidth-1:0] in_weight;
  logic [dataWidth-1:0]   bias;
  logic                   out_valid;
  logic                   out_ready;
  logic [sumWidth-1:0]    out_sum;

  modport master (
    input  in_valid, in_data, in_weight, bias, out_ready,
    output in_ready, out_valid, out_sum
  );
  modport slave (
    output in_valid, in_data, in_weight, bias, out_ready,
    input  in_ready, out_valid, out_sum
  );
endinterface

// File: rtl/neuron_mac.sv
// Per-neuron multiply-accumulate: registered product, saturating accumulate, bias add,
// then the sum is held on a valid/ready port until the activation stage takes it.
module neuron_mac #(
  parameter int sumWidth        = 32,
  parameter int sumIntWidth     = 15,
  parameter int sumFracWidth    = 17,
  parameter int dataWidth       = 16,
  parameter int dataFracWidth   = 10,
  parameter int weightWidth     = 16,
  parameter int weightFracWidth = 10,
  parameter int numInputs       = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clear,
  neuron_mac_if.master  bus
);
  if (sumIntWidth + sumFracWidth != sumWidth || numInputs < 1) begin : g_param_chk
    $error("neuron_mac: inconsistent parameters");
  end

  localparam int PW   = dataWidth + weightWidth;
  localparam int SH   = dataFracWidth + weightFracWidth - sumFracWidth;
  localparam int BSH  = sumFracWidth - dataFracWidth;
  localparam int unsigned SHR  = (SH  > 0) ? SH   : 0;
  localparam int unsigned SHL  = (SH  < 0) ? -SH  : 0;
  localparam int unsigned BSHR = (BSH < 0) ? -BSH : 0;
  localparam int unsigned BSHL = (BSH > 0) ? BSH  : 0;
  // Work width holds any aligned term plus the accumulator with headroom, so the clamp sees the true sum.
  localparam int W1   = (PW + int'(SHL) > sumWidth) ? PW + int'(SHL) : sumWidth;
  localparam int AW   = ((dataWidth + int'(BSHL) > W1) ? dataWidth + int'(BSHL) : W1) + 2;
  localparam int CW   = $clog2(numInputs + 1);
  localparam logic [CW-1:0] LAST = CW'(numInputs - 1);
  localparam logic signed [AW-1:0] SMAX = {{(AW-sumWidth+1){1'b0}}, {(sumWidth-1){1'b1}}};
  localparam logic signed [AW-1:0] SMIN = ~SMAX;

  typedef enum logic [1:0] {ACCUM, DRAIN, BIAS, OUT} state_t;

  state_t                      state, state_nx;
  logic                        in_ready, out_valid, accept, handshake;
  logic [CW-1:0]               count;
  logic                        prod_vld;
  logic signed [PW-1:0]        prod;
  logic signed [sumWidth-1:0]  acc;
  logic [sumWidth-1:0]         sum_q;
  logic signed [AW-1:0]        acc_x, prod_x, bias_x, acc_p, acc_b;

  function automatic logic signed [sumWidth-1:0] sat(input logic signed [AW-1:0] v);
    if (v > SMAX)      return SMAX[sumWidth-1:0];
    else if (v < SMIN) return SMIN[sumWidth-1:0];
    else               return v[sumWidth-1:0];
  endfunction

  always_comb begin
    state_nx  = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    unique case (state)
      ACCUM: begin
        in_ready = 1'b1;
        if (bus.in_valid && count == LAST) state_nx = DRAIN;
      end
      DRAIN: state_nx = BIAS;
      BIAS:  state_nx = OUT;
      OUT: begin
        out_valid = 1'b1;
        if (bus.out_ready) state_nx = ACCUM;
      end
    endcase
    if (clear) state_nx = ACCUM;
  end

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= ACCUM;
    else        state <= state_nx;

  assign accept        = bus.in_valid && in_ready;
  assign handshake     = out_valid && bus.out_ready;
  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid;
  assign bus.out_sum   = sum_q;

  // Alignment: one of each shift pair is zero, so a negative fraction difference becomes a left shift.
  always_comb begin
    acc_x  = AW'(acc);
    prod_x = AW'(prod);
    prod_x = (prod_x >>> SHR) <<< SHL;
    bias_x = AW'($signed(bus.bias));
    bias_x = (bias_x >>> BSHR) <<< BSHL;
    acc_p  = acc_x + prod_x;
    acc_b  = acc_x + bias_x;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc      <= '0;
      count    <= '0;
      prod     <= '0;
      prod_vld <= 1'b0;
      sum_q    <= '0;
    end else if (clear) begin
      acc      <= '0;
      count    <= '0;
      prod_vld <= 1'b0;
    end else begin
      prod_vld <= accept;
      if (accept) begin
        prod  <= PW'($signed(bus.in_data)) * PW'($signed(bus.in_weight));
        count <= count + 1'b1;
      end
      if (prod_vld) acc <= sat(acc_p);
      if (state == BIAS) begin
        acc   <= sat(acc_b);
        sum_q <= sat(acc_b);
      end
      if (handshake) begin
        acc   <= '0;
        count <= '0;
      end
    end
  end
endmodule

// File: tb/tb_neuron_mac.sv
// Randomized bench for neuron_mac: 32-bit and 24-bit sum instances run in lock-step
// against an integer-arithmetic model of the saturating MAC.
module tb_neuron_mac;
  localparam int N = 4;

  logic        clk = 1'b0;
  logic        rst_n, clear, in_valid, out_ready;
  logic [15:0] in_data, in_weight, bias;
  int          checks = 0, failures = 0;

  logic [15:0] vd [N];
  logic [15:0] vw [N];
  logic [15:0] vb;
  logic [63:0] last_a, last_b;

  always #5 clk = ~clk;

  neuron_mac_if #(.dataWidth(16), .weightWidth(16), .sumWidth(32)) ia();
  neuron_mac_if #(.dataWidth(16), .weightWidth(16), .sumWidth(24)) ib();

  assign ia.in_valid = in_valid;  assign ib.in_valid = in_valid;
  assign ia.in_data = in_data;    assign ib.in_data = in_data;
  assign ia.in_weight = in_weight; assign ib.in_weight = in_weight;
  assign ia.bias = bias;          assign ib.bias = bias;
  assign ia.out_ready = out_ready; assign ib.out_ready = out_ready;

  neuron_mac #(.numInputs(N)) u_a (.clk(clk), .rst_n(rst_n), .clear(clear), .bus(ia.master));
  neuron_mac #(.sumWidth(24), .sumIntWidth(7), .numInputs(N))
    u_b (.clk(clk), .rst_n(rst_n), .clear(clear), .bus(ib.master));

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] sx32(input logic [31:0] v);
    return {{32{v[31]}}, v};
  endfunction
  function automatic logic [63:0] sx24(input logic [23:0] v);
    return {{40{v[23]}}, v};
  endfunction

  function automatic longint clampw(input longint v, input int sw);
    longint hi = (longint'(1) << (sw - 1)) - 1;
    longint lo = -(longint'(1) << (sw - 1));
    return (v > hi) ? hi : (v < lo) ? lo : v;
  endfunction

  // Q12.20 product to Q.17, rounded toward -inf, then bias scaled by 2^7.
  function automatic longint model(input int sw);
    longint acc = 0, p, r;
    for (int i = 0; i < N; i++) begin
      p = longint'($signed(vd[i])) * longint'($signed(vw[i]));
      r = p % 8;
      if (r < 0) r += 8;
      acc = clampw(acc + (p - r) / 8, sw);
    end
    return clampw(acc + longint'($signed(vb)) * 128, sw);
  endfunction

  task automatic set_vec(input logic [15:0] d, input logic [15:0] w, input logic [15:0] b);
    for (int i = 0; i < N; i++) begin vd[i] = d; vw[i] = w; end
    vb = b;
  endtask

  task automatic send_beats(input int n, input int gap);
    int i = 0, guard = 0;
    logic acc_now;
    bias = vb;
    while (i < n && guard < 1000) begin
      @(negedge clk);
      in_valid  = ($urandom_range(0, 99) >= gap);
      in_data   = in_valid ? vd[i] : 16'($urandom);
      in_weight = in_valid ? vw[i] : 16'($urandom);
      acc_now   = in_valid && ia.in_ready;
      @(posedge clk);
      if (acc_now) i++;
      guard++;
    end
    chk("beats", 64'(i), 64'(n));
  endtask

  task automatic finish_vec(input int hold);
    int   lat = 1;
    logic stable = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    chk("rdy_drain", 64'(ia.in_ready), 64'(0));
    while (!ia.out_valid && lat < 20) begin
      @(posedge clk); lat++; @(negedge clk);
    end
    chk("lat", 64'(lat), 64'(3));
    chk("vld_b", 64'(ib.out_valid), 64'(1));
    last_a = sx32(ia.out_sum);
    last_b = sx24(ib.out_sum);
    chk("sum_a", last_a, 64'(model(32)));
    chk("sum_b", last_b, 64'(model(24)));
    repeat (hold) begin
      @(posedge clk); @(negedge clk);
      if (ia.out_valid !== 1'b1 || sx32(ia.out_sum) !== last_a || ia.in_ready !== 1'b0) stable = 1'b0;
    end
    chk("hold", 64'(stable), 64'(1));
    out_ready = 1'b1;
    @(posedge clk); @(negedge clk);
    out_ready = 1'b0;
    chk("release", 64'({ia.out_valid, ia.in_ready}), 64'(2'b01));
  endtask

  task automatic run_vec(input int gap, input int hold);
    send_beats(N, gap);
    finish_vec(hold);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog time limit");
    $fatal(1);
  end

  initial begin
    logic seen;
    rst_n = 1'b0; clear = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_data = '0; in_weight = '0; bias = '0;
    #23;
    chk("rst_vld", 64'({ia.out_valid, ib.out_valid}), 64'(0));
    chk("rst_rdy", 64'({ia.in_ready, ib.in_ready}), 64'(2'b11));
    chk("rst_sum", 64'(ia.out_sum), 64'(0));
    @(negedge clk) rst_n = 1'b1;

    set_vec(16'h0400, 16'h0200, 16'h0100); run_vec(0, 0);
    chk("t1_a", last_a, 64'h48000);
    set_vec(16'hFC00, 16'h0800, 16'h0000); run_vec(0, 0);
    chk("t2_a", last_a, 64'hFFFF_FFFF_FFF0_0000);
    set_vec(16'h2000, 16'h2000, 16'h0000); run_vec(0, 0);
    chk("t3_pos_b", last_b, 64'h7F_FFFF);
    chk("t3_pos_a", last_a, 64'h0200_0000);
    set_vec(16'hE000, 16'h2000, 16'h0000); run_vec(0, 0);
    chk("t3_neg_b", last_b, 64'hFFFF_FFFF_FF80_0000);

    set_vec(16'h0400, 16'h0200, 16'h0100); run_vec(0, 5);
    run_vec(0, 0);
    chk("t4_next", last_a, 64'h48000);
    run_vec(50, 1);
    chk("t5_gaps", last_a, 64'h48000);

    // Async reset mid-cycle after two beats, then again while a sum is being presented.
    send_beats(2, 0);
    #2 rst_n = 1'b0;
    #1 chk("t6_rst_acc", 64'({ia.out_valid, ia.in_ready}), 64'(2'b01));
    @(negedge clk); rst_n = 1'b1; in_valid = 1'b0;
    run_vec(0, 0);
    chk("t6_after", last_a, 64'h48000);
    send_beats(N, 0);
    @(negedge clk); in_valid = 1'b0;
    begin
      int g = 0;
      while (!ia.out_valid && g < 20) begin @(negedge clk); g++; end
    end
    chk("t6_out_seen", 64'(ia.out_valid), 64'(1));
    #2 rst_n = 1'b0;
    #1 chk("t6_rst_out", 64'({ia.out_valid, ia.in_ready, ia.out_sum}), 64'({2'b01, 32'h0}));
    @(negedge clk); rst_n = 1'b1;

    // Clear while draining: the sum must never appear.
    send_beats(N, 0);
    @(negedge clk); in_valid = 1'b0; clear = 1'b1;
    chk("clr_drain_rdy", 64'(ia.in_ready), 64'(0));
    @(negedge clk); clear = 1'b0;
    seen = 1'b0;
    repeat (5) begin @(negedge clk); if (ia.out_valid || ib.out_valid) seen = 1'b1; end
    chk("clr_novld", 64'(seen), 64'(0));
    chk("clr_rdy", 64'(ia.in_ready), 64'(1));
    run_vec(0, 0);
    chk("clr_after", last_a, 64'h48000);

    for (int v = 0; v < 25; v++) begin
      for (int i = 0; i < N; i++) begin
        if ($urandom_range(0, 1) != 0) begin
          vd[i] = 16'($urandom); vw[i] = 16'($urandom);
        end else begin
          vd[i] = 16'(int'($urandom_range(0, 4095)) - 2048);
          vw[i] = 16'(int'($urandom_range(0, 4095)) - 2048);
        end
      end
      vb = 16'($urandom);
      run_vec(int'($urandom_range(0, 60)), int'($urandom_range(0, 3)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
